// File: rtl/id_ex_stage_if.sv
// ID/EX stage bundle: decoded ID fields, forwarding sources and control in; ALU operands out.
// master is the surrounding pipeline, slave is the id_ex_stage itself.
interface id_ex_stage_if #(
    parameter int unsigned DW  = 32,
    parameter int unsigned RW  = 5,
    parameter int unsigned OPW = 5
);
    logic           id_valid;
    logic [RW-1:0]  id_rs;
    logic [RW-1:0]  id_rt;
    logic           id_rt_used;
    logic [RW-1:0]  id_rd;
    logic [DW-1:0]  id_rs_data;
    logic [DW-1:0]  id_rt_data;
    logic [DW-1:0]  id_imm;
    logic [4:0]     id_shamt;
    logic [OPW-1:0] id_alu_op;
    logic           id_alu_src;
    logic           id_reg_write;
    logic           id_mem_read;
    logic           id_mem_write;
    logic           flush;
    logic           ex_hold;
    logic           mem_reg_write;
    logic [RW-1:0]  mem_rd;
    logic [DW-1:0]  mem_fwd_data;
    logic           wb_reg_write;
    logic [RW-1:0]  wb_rd;
    logic [DW-1:0]  wb_data;

    logic           id_stall;
    logic [DW-1:0]  alu_a;
    logic [DW-1:0]  alu_b;
    logic [OPW-1:0] alu_op;
    logic [4:0]     alu_shamt;
    logic [DW-1:0]  ex_store_data;
    logic [RW-1:0]  ex_rd;
    logic           ex_valid;
    logic           ex_reg_write;
    logic           ex_mem_read;
    logic           ex_mem_write;

    modport master (
        output id_valid, id_rs, id_rt, id_rt_used, id_rd, id_rs_data, id_rt_data, id_imm,
               id_shamt, id_alu_op, id_alu_src, id_reg_write, id_mem_read, id_mem_write,
               flush, ex_hold, mem_reg_write, mem_rd, mem_fwd_data, wb_reg_write, wb_rd,
               wb_data,
        input  id_stall, alu_a, alu_b, alu_op, alu_shamt, ex_store_data, ex_rd, ex_valid,
               ex_reg_write, ex_mem_read, ex_mem_write
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rt_used, id_rd, id_rs_data, id_rt_data, id_imm,
               id_shamt, id_alu_op, id_alu_src, id_reg_write, id_mem_read, id_mem_write,
               flush, ex_hold, mem_reg_write, mem_rd, mem_fwd_data, wb_reg_write, wb_rd,
               wb_data,
        output id_stall, alu_a, alu_b, alu_op, alu_shamt, ex_store_data, ex_rd, ex_valid,
               ex_reg_write, ex_mem_read, ex_mem_write
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, hold/flush handling and
// EX/MEM > MEM/WB operand forwarding in front of the ALU.
module id_ex_stage #(
    parameter int unsigned DW  = 32,
    parameter int unsigned RW  = 5,
    parameter int unsigned OPW = 5
) (
    input logic          clk,
    input logic          rstn,
    id_ex_stage_if.slave bus
);

    logic           r_valid;
    logic           r_reg_write;
    logic           r_mem_read;
    logic           r_mem_write;
    logic [OPW-1:0] r_alu_op;
    logic           r_alu_src;
    logic [RW-1:0]  r_rs;
    logic [RW-1:0]  r_rt;
    logic [RW-1:0]  r_rd;
    logic [DW-1:0]  r_rs_data;
    logic [DW-1:0]  r_rt_data;
    logic [DW-1:0]  r_imm;
    logic [4:0]     r_shamt;

    logic           w_rs_match;
    logic           w_rt_match;
    logic           w_hazard;
    logic           w_bubble;
    logic [DW-1:0]  w_fwd_a;
    logic [DW-1:0]  w_fwd_b;

    // Load in EX whose destination the ID instruction reads: result not ready until MEM.
    always_comb begin
        w_rs_match = (r_rd == bus.id_rs);
        w_rt_match = bus.id_rt_used && (r_rd == bus.id_rt);
        w_hazard   = r_valid && r_mem_read && (r_rd != '0) && (w_rs_match || w_rt_match) &&
                     bus.id_valid;
        w_bubble   = bus.flush || w_hazard;
    end

    assign bus.id_stall = bus.ex_hold || (w_hazard && !bus.flush);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_alu_op    <= '0;
            r_alu_src   <= 1'b0;
            r_rs        <= '0;
            r_rt        <= '0;
            r_rd        <= '0;
            r_rs_data   <= '0;
            r_rt_data   <= '0;
            r_imm       <= '0;
            r_shamt     <= '0;
        end else if (!bus.ex_hold) begin
            if (w_bubble) begin
                r_valid     <= 1'b0;
                r_reg_write <= 1'b0;
                r_mem_read  <= 1'b0;
                r_mem_write <= 1'b0;
                r_alu_op    <= '0;
            end else begin
                // An empty ID slot enters EX as a bubble with every control cleared.
                r_valid     <= bus.id_valid;
                r_reg_write <= bus.id_valid && bus.id_reg_write;
                r_mem_read  <= bus.id_valid && bus.id_mem_read;
                r_mem_write <= bus.id_valid && bus.id_mem_write;
                r_alu_op    <= bus.id_valid ? bus.id_alu_op : '0;
                r_alu_src   <= bus.id_alu_src;
                r_rs        <= bus.id_rs;
                r_rt        <= bus.id_rt;
                r_rd        <= bus.id_rd;
                r_rs_data   <= bus.id_rs_data;
                r_rt_data   <= bus.id_rt_data;
                r_imm       <= bus.id_imm;
                r_shamt     <= bus.id_shamt;
            end
        end
    end

    always_comb begin
        w_fwd_a = r_rs_data;
        if (bus.mem_reg_write && (bus.mem_rd != '0) && (bus.mem_rd == r_rs)) begin
            w_fwd_a = bus.mem_fwd_data;
        end else if (bus.wb_reg_write && (bus.wb_rd != '0) && (bus.wb_rd == r_rs)) begin
            w_fwd_a = bus.wb_data;
        end
    end

    always_comb begin
        w_fwd_b = r_rt_data;
        if (bus.mem_reg_write && (bus.mem_rd != '0) && (bus.mem_rd == r_rt)) begin
            w_fwd_b = bus.mem_fwd_data;
        end else if (bus.wb_reg_write && (bus.wb_rd != '0) && (bus.wb_rd == r_rt)) begin
            w_fwd_b = bus.wb_data;
        end
    end

    assign bus.alu_a         = w_fwd_a;
    assign bus.alu_b         = r_alu_src ? r_imm : w_fwd_b;
    assign bus.ex_store_data = w_fwd_b;
    assign bus.alu_op        = r_alu_op;
    assign bus.alu_shamt     = r_shamt;
    assign bus.ex_rd         = r_rd;
    assign bus.ex_valid      = r_valid;
    assign bus.ex_reg_write  = r_reg_write;
    assign bus.ex_mem_read   = r_mem_read;
    assign bus.ex_mem_write  = r_mem_write;

endmodule
